// File: rtl/exec_ctrl.sv
// Execution controller: gates a CPU's register-update enable for halt, free-run at a
// divided rate, single-step and CPU reset, with a sticky instruction-address breakpoint.
module exec_ctrl #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_run,
    input  logic             i_cmd_halt,
    input  logic             i_cmd_step,
    input  logic             i_cmd_reset,
    input  logic [DIV_W-1:0] i_rate_div,
    input  logic             i_bp_en,
    input  logic [3:0]       i_bp_addr,
    input  logic [3:0]       i_cpu_addr,
    output logic             o_cpu_en,
    output logic             o_cpu_rst,
    output logic [1:0]       o_state,
    output logic             o_bp_hit,
    output logic [CNT_W-1:0] o_instr_count
);

    typedef enum logic [1:0] {
        StHalt   = 2'd0,
        StRun    = 2'd1,
        StStep   = 2'd2,
        StCpuRst = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_rst_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_skip_bp;
    logic             r_bp_hit;
    logic [CNT_W-1:0] r_instr_count;

    logic w_tick;
    logic w_bp_block;
    logic w_cpu_en;

    // >= compare so lowering rate_div below the running count ticks on the next cycle.
    assign w_tick     = (r_state == StRun) && (r_div_cnt >= i_rate_div);
    assign w_bp_block = w_tick && i_bp_en && (i_cpu_addr == i_bp_addr) && !r_skip_bp;
    assign w_cpu_en   = !i_reset && ((w_tick && !w_bp_block) || (r_state == StStep));

    assign o_cpu_en      = w_cpu_en;
    assign o_cpu_rst     = i_reset || (r_state == StCpuRst);
    assign o_state       = r_state;
    assign o_bp_hit      = r_bp_hit;
    assign o_instr_count = r_instr_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_cmd_reset) begin
            r_state       <= StCpuRst;
            r_rst_cnt     <= 1'b0;
            r_div_cnt     <= '0;
            r_skip_bp     <= 1'b0;
            r_bp_hit      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            if (w_cpu_en && (r_instr_count != {CNT_W{1'b1}})) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
            unique case (r_state)
                StHalt: begin
                    if (i_cmd_halt) begin
                        r_state <= StHalt;
                    end else if (i_cmd_run) begin
                        r_state   <= StRun;
                        r_div_cnt <= '0;
                        r_skip_bp <= 1'b1;
                        r_bp_hit  <= 1'b0;
                    end else if (i_cmd_step) begin
                        r_state  <= StStep;
                        r_bp_hit <= 1'b0;
                    end
                end
                StRun: begin
                    r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                    if (w_cpu_en) begin
                        r_skip_bp <= 1'b0;
                    end
                    if (w_bp_block) begin
                        r_bp_hit <= 1'b1;
                    end
                    if (w_bp_block || i_cmd_halt) begin
                        r_state <= StHalt;
                    end
                end
                StStep: begin
                    r_state <= StHalt;
                end
                StCpuRst: begin
                    // Two cycles of CPU reset: count 0 then 1, then release to HALT.
                    if (r_rst_cnt) begin
                        r_state <= StHalt;
                    end
                    r_rst_cnt <= 1'b1;
                end
            endcase
        end
    end

endmodule
